// File: rtl/zpu_ioctl_bridge_pkg.sv
`default_nettype none
// ============================================================================
// zpu_ioctl_pkg : shared types and helpers for the ZPU boot-data/ioctl bridge
// Rev 1.0
// ============================================================================
package zpu_ioctl_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_ACK   = 3'd2,
        S_EMIT  = 3'd3,
        S_GAP   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [2:0] FT_ROM = 3'b111;

    // The ROM file type maps to menu index 0; every other type is its own index.
    function automatic logic [15:0] ft_to_index(input logic [2:0] ft);
        return (ft == FT_ROM) ? 16'd0 : {13'b0, ft};
    endfunction

endpackage
`default_nettype wire

// File: rtl/zpu_ioctl_bridge_if.sv
`default_nettype none
// ============================================================================
// zpu_ioctl_bridge_if : ZPU boot-data port plus ioctl download bus
// Rev 1.0
// ============================================================================
interface zpu_ioctl_bridge_if #(
    parameter int DW     = 8,
    parameter int ADDR_W = 27,
    parameter int SIZE_W = 16
) ();
    logic [31:0]       host_bootdata;
    logic              host_bootdata_req;
    logic              host_bootdata_ack;
    logic              host_bootdata_download;
    logic [SIZE_W-1:0] host_bootdata_size;
    logic [2:0]        host_file_type;
    logic              ioctl_download;
    logic [15:0]       ioctl_index;
    logic              ioctl_wr;
    logic [ADDR_W-1:0] ioctl_addr;
    logic [DW-1:0]     ioctl_dout;
    logic              ioctl_wait;
    logic [SIZE_W-1:0] words_done;

    // master is the bridge; slave is the ZPU/target environment around it
    modport master (
        input  host_bootdata, host_bootdata_req, host_bootdata_download,
               host_bootdata_size, host_file_type, ioctl_wait,
        output host_bootdata_ack, ioctl_download, ioctl_index, ioctl_wr,
               ioctl_addr, ioctl_dout, words_done
    );

    modport slave (
        output host_bootdata, host_bootdata_req, host_bootdata_download,
               host_bootdata_size, host_file_type, ioctl_wait,
        input  host_bootdata_ack, ioctl_download, ioctl_index, ioctl_wr,
               ioctl_addr, ioctl_dout, words_done
    );
endinterface
`default_nettype wire

// File: rtl/zpu_ioctl_bridge.sv
`default_nettype none
// ============================================================================
// zpu_ioctl_bridge : splits ZPU 32-bit boot words into 8/16-bit ioctl writes
// Rev 1.0
// ============================================================================
module zpu_ioctl_bridge
    import zpu_ioctl_pkg::*;
#(
    parameter int WIDE   = 0,
    parameter int ADDR_W = 27,
    parameter int SIZE_W = 16,
    parameter int GAP    = 3
) (
    input  logic               clk_sys,
    input  logic               reset,
    zpu_ioctl_bridge_if.master bus
);
    localparam int              DW        = (WIDE != 0) ? 16 : 8;
    localparam int              NLANES    = (WIDE != 0) ? 2 : 4;
    localparam logic [1:0]      LAST_LANE = 2'(NLANES - 1);
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'((WIDE != 0) ? 2 : 1);
    localparam int              GW        = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GW-1:0]   GAP_LAST  = GW'(GAP - 1);

    state_t            state_q;
    logic [31:0]       word_q;
    logic [1:0]        lane_q;
    logic [GW-1:0]     gap_q;
    logic              ack_q;
    logic              download_q;
    logic [15:0]       index_q;
    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DW-1:0]     dout_q;
    logic [SIZE_W-1:0] words_q;
    logic [DW-1:0]     lane_data;

    // Big-endian stream: the byte destined for the lower address goes out first.
    generate
        if (WIDE != 0) begin : g_wide
            assign lane_data = lane_q[0] ? {word_q[7:0],   word_q[15:8]}
                                         : {word_q[23:16], word_q[31:24]};
        end else begin : g_narrow
            always_comb begin
                lane_data = word_q[31:24];
                case (lane_q)
                    2'd1:    lane_data = word_q[23:16];
                    2'd2:    lane_data = word_q[15:8];
                    2'd3:    lane_data = word_q[7:0];
                    default: lane_data = word_q[31:24];
                endcase
            end
        end
    endgenerate

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q    <= S_IDLE;
            word_q     <= '0;
            lane_q     <= '0;
            gap_q      <= '0;
            ack_q      <= 1'b0;
            download_q <= 1'b0;
            index_q    <= '0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            dout_q     <= '0;
            words_q    <= '0;
        end else begin
            ack_q <= 1'b0;
            wr_q  <= 1'b0;
            // Address moves on only after the strobe cycle has presented it.
            if (wr_q) addr_q <= addr_q + ADDR_STEP;

            case (state_q)
                S_IDLE: begin
                    if (bus.host_bootdata_download) begin
                        addr_q     <= '0;
                        words_q    <= '0;
                        index_q    <= ft_to_index(bus.host_file_type);
                        download_q <= 1'b1;
                        state_q    <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (bus.host_bootdata_req) begin
                        word_q  <= bus.host_bootdata;
                        ack_q   <= 1'b1;
                        state_q <= S_ACK;
                    end else if (!bus.host_bootdata_download) begin
                        state_q <= S_DONE;
                    end
                end
                S_ACK: begin
                    if (!bus.host_bootdata_req) begin
                        if ((bus.host_bootdata_size != '0) &&
                            (words_q >= bus.host_bootdata_size)) begin
                            state_q <= S_FETCH;
                        end else begin
                            lane_q  <= '0;
                            state_q <= S_EMIT;
                        end
                    end
                end
                S_EMIT: begin
                    if (!bus.ioctl_wait) begin
                        wr_q    <= 1'b1;
                        dout_q  <= lane_data;
                        gap_q   <= '0;
                        state_q <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (gap_q == GAP_LAST) begin
                        if (lane_q != LAST_LANE) begin
                            lane_q  <= lane_q + 2'd1;
                            state_q <= S_EMIT;
                        end else begin
                            if (words_q != '1) words_q <= words_q + 1'b1;
                            state_q <= S_FETCH;
                        end
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                end
                S_DONE: begin
                    download_q <= 1'b0;
                    state_q    <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.host_bootdata_ack = ack_q;
    assign bus.ioctl_download    = download_q;
    assign bus.ioctl_index       = index_q;
    assign bus.ioctl_wr          = wr_q;
    assign bus.ioctl_addr        = addr_q;
    assign bus.ioctl_dout        = dout_q;
    assign bus.words_done        = words_q;

endmodule
`default_nettype wire

// File: tb/tb_zpu_ioctl_bridge.sv
`default_nettype none
// ============================================================================
// tb_zpu_ioctl_bridge : directed vectors for the 8-bit and 16-bit bridge builds
// Rev 1.0
// ============================================================================
module tb_zpu_ioctl_bridge;

    logic clk_sys = 1'b0;
    logic reset;
    always #5 clk_sys = ~clk_sys;

    zpu_ioctl_bridge_if #(.DW(8),  .ADDR_W(27), .SIZE_W(16)) ifn ();
    zpu_ioctl_bridge_if #(.DW(16), .ADDR_W(27), .SIZE_W(16)) ifw ();

    zpu_ioctl_bridge #(.WIDE(0), .ADDR_W(27), .SIZE_W(16), .GAP(3)) dut_n (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (ifn)
    );

    zpu_ioctl_bridge #(.WIDE(1), .ADDR_W(27), .SIZE_W(16), .GAP(3)) dut_w (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (ifw)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int ack_n = 0;
    int ack_w = 0;
    logic [31:0] qa[$], qd[$], wa[$], wd[$];
    int          qc[$], wc[$];

    always @(posedge clk_sys) cyc <= cyc + 1;

    always @(negedge clk_sys) begin
        if (ifn.ioctl_wr) begin
            qa.push_back(32'(ifn.ioctl_addr));
            qd.push_back(32'(ifn.ioctl_dout));
            qc.push_back(cyc);
        end
        if (ifw.ioctl_wr) begin
            wa.push_back(32'(ifw.ioctl_addr));
            wd.push_back(32'(ifw.ioctl_dout));
            wc.push_back(cyc);
        end
        if (ifn.host_bootdata_ack) ack_n++;
        if (ifw.host_bootdata_ack) ack_w++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic clear_n();
        qa.delete(); qd.delete(); qc.delete(); ack_n = 0;
    endtask

    // ZPU side: hold req until ack, then drop it for a cycle so ACK can complete.
    task automatic send_n(input logic [31:0] w, input string tag);
        bit seen;
        seen = 1'b0;
        ifn.host_bootdata     = w;
        ifn.host_bootdata_req = 1'b1;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk_sys);
            if (ifn.host_bootdata_ack) seen = 1'b1;
        end
        ifn.host_bootdata_req = 1'b0;
        check(tag, 32'(seen), 32'd1);
        @(negedge clk_sys);
    endtask

    task automatic send_w(input logic [31:0] w, input string tag);
        bit seen;
        seen = 1'b0;
        ifw.host_bootdata     = w;
        ifw.host_bootdata_req = 1'b1;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk_sys);
            if (ifw.host_bootdata_ack) seen = 1'b1;
        end
        ifw.host_bootdata_req = 1'b0;
        check(tag, 32'(seen), 32'd1);
        @(negedge clk_sys);
    endtask

    task automatic wait_dl_low_n(input string tag);
        for (int i = 0; i < 300 && ifn.ioctl_download; i++) @(negedge clk_sys);
        check(tag, 32'(ifn.ioctl_download), 32'd0);
    endtask

    task automatic wait_writes_n(input int n, input string tag);
        for (int i = 0; i < 300 && qa.size() < n; i++) @(negedge clk_sys);
        check(tag, 32'(qa.size()), 32'(n));
    endtask

    logic [7:0] e1 [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    logic [7:0] e2 [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};

    initial begin
        reset = 1'b1;
        ifn.host_bootdata = '0; ifn.host_bootdata_req = 1'b0; ifn.host_bootdata_download = 1'b0;
        ifn.host_bootdata_size = '0; ifn.host_file_type = '0; ifn.ioctl_wait = 1'b0;
        ifw.host_bootdata = '0; ifw.host_bootdata_req = 1'b0; ifw.host_bootdata_download = 1'b0;
        ifw.host_bootdata_size = '0; ifw.host_file_type = '0; ifw.ioctl_wait = 1'b0;
        tick(3);
        check("rst_download", 32'(ifn.ioctl_download), 32'd0);
        check("rst_wr",       32'(ifn.ioctl_wr), 32'd0);
        check("rst_ack",      32'(ifn.host_bootdata_ack), 32'd0);
        check("rst_addr",     32'(ifn.ioctl_addr), 32'd0);
        check("rst_dout",     32'(ifn.ioctl_dout), 32'd0);
        check("rst_index",    32'(ifn.ioctl_index), 32'd0);
        check("rst_words",    32'(ifn.words_done), 32'd0);
        reset = 1'b0;
        tick(2);

        // Basic 8-bit transfer, ROM file type
        clear_n();
        ifn.host_bootdata_size = 16'd2;
        ifn.host_file_type = 3'b111;
        ifn.host_bootdata_download = 1'b1;
        tick(1);
        check("t1_dl_rise", 32'(ifn.ioctl_download), 32'd1);
        check("t1_index_rom", 32'(ifn.ioctl_index), 32'd0);
        send_n(32'h11223344, "t1_ack0");
        send_n(32'h55667788, "t1_ack1");
        ifn.host_bootdata_download = 1'b0;
        wait_dl_low_n("t1_dl_fall");
        check("t1_nwrites", 32'(qa.size()), 32'd8);
        for (int i = 0; i < 8 && i < qa.size(); i++) begin
            check("t1_addr", qa[i], 32'(i));
            check("t1_data", qd[i], 32'(e1[i]));
        end
        check("t1_words_done", 32'(ifn.words_done), 32'd2);
        check("t1_ack_cycles", 32'(ack_n), 32'd2);
        if (qc.size() >= 2) check("t1_gap_ge4", 32'((qc[1] - qc[0]) >= 4), 32'd1);

        // Back-pressure: wait held for 10 cycles while the word sits in EMIT
        tick(2);
        clear_n();
        ifn.host_bootdata_size = 16'd0;
        ifn.ioctl_wait = 1'b1;
        ifn.host_bootdata_download = 1'b1;
        tick(1);
        send_n(32'hA1B2C3D4, "t2_ack");
        tick(10);
        check("t2_no_wr_stall", 32'(qa.size()), 32'd0);
        ifn.ioctl_wait = 1'b0;
        ifn.host_bootdata_download = 1'b0;
        wait_dl_low_n("t2_dl_fall");
        check("t2_nwrites", 32'(qa.size()), 32'd4);
        for (int i = 0; i < 4 && i < qa.size(); i++) begin
            check("t2_addr", qa[i], 32'(i));
            check("t2_data", qd[i], 32'(e2[i]));
        end

        // Size limit: second word acked but dropped; also non-ROM index
        tick(2);
        clear_n();
        ifn.host_bootdata_size = 16'd1;
        ifn.host_file_type = 3'b010;
        ifn.host_bootdata_download = 1'b1;
        tick(1);
        check("t4_index_2", 32'(ifn.ioctl_index), 32'd2);
        send_n(32'h01020304, "t4_ack0");
        send_n(32'h05060708, "t4_ack1");
        ifn.host_bootdata_download = 1'b0;
        wait_dl_low_n("t4_dl_fall");
        check("t4_nwrites", 32'(qa.size()), 32'd4);
        for (int i = 0; i < 4 && i < qa.size(); i++)
            check("t4_data", qd[i], 32'(i + 1));
        check("t4_words_done", 32'(ifn.words_done), 32'd1);
        check("t4_ack_cycles", 32'(ack_n), 32'd2);

        // Reset while the second word is stalled in EMIT
        tick(2);
        clear_n();
        ifn.host_bootdata_size = 16'd0;
        ifn.host_file_type = 3'b001;
        ifn.host_bootdata_download = 1'b1;
        tick(1);
        check("t5_index_1", 32'(ifn.ioctl_index), 32'd1);
        send_n(32'h11223344, "t5_ack0");
        wait_writes_n(4, "t5_first_word");
        ifn.ioctl_wait = 1'b1;
        send_n(32'h55667788, "t5_ack1");
        tick(2);
        reset = 1'b1;
        ifn.host_bootdata_download = 1'b0;
        ifn.ioctl_wait = 1'b0;
        clear_n();
        tick(1);
        check("t5_rst_download", 32'(ifn.ioctl_download), 32'd0);
        check("t5_rst_addr",     32'(ifn.ioctl_addr), 32'd0);
        check("t5_rst_dout",     32'(ifn.ioctl_dout), 32'd0);
        check("t5_rst_index",    32'(ifn.ioctl_index), 32'd0);
        check("t5_rst_words",    32'(ifn.words_done), 32'd0);
        reset = 1'b0;
        tick(10);
        check("t5_no_wr_after_rst", 32'(qa.size()), 32'd0);
        ifn.host_bootdata_download = 1'b1;
        tick(1);
        send_n(32'h11223344, "t5_ack2");
        wait_writes_n(1, "t5_restart_wr");
        if (qa.size() >= 1) begin
            check("t5_restart_addr", qa[0], 32'd0);
            check("t5_restart_data", qd[0], 32'h11);
        end
        ifn.host_bootdata_download = 1'b0;
        wait_dl_low_n("t5_dl_fall");

        // 16-bit build
        ifw.host_bootdata_size = 16'd0;
        ifw.host_file_type = 3'b011;
        ifw.host_bootdata_download = 1'b1;
        tick(1);
        check("t3_index_3", 32'(ifw.ioctl_index), 32'd3);
        send_w(32'hAABBCCDD, "t3_ack");
        ifw.host_bootdata_download = 1'b0;
        for (int i = 0; i < 300 && ifw.ioctl_download; i++) @(negedge clk_sys);
        check("t3_dl_fall", 32'(ifw.ioctl_download), 32'd0);
        check("t3_nwrites", 32'(wa.size()), 32'd2);
        if (wa.size() >= 2) begin
            check("t3_addr0", wa[0], 32'd0);
            check("t3_data0", wd[0], 32'hBBAA);
            check("t3_addr1", wa[1], 32'd2);
            check("t3_data1", wd[1], 32'hDDCC);
            check("t3_gap_ge4", 32'((wc[1] - wc[0]) >= 4), 32'd1);
        end
        check("t3_addr_end", 32'(ifw.ioctl_addr), 32'd4);
        check("t3_words_done", 32'(ifw.words_done), 32'd1);
        check("t3_ack_cycles", 32'(ack_w), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/zpu_ioctl_bridge.md
# zpu_ioctl_bridge

Parametrised bridge between the ZPUFlex control module's boot-data port and the MiSTer-style ioctl download bus, for zxdos/zxuno cores. Successor to the fixed 8-bit loader: it supports 8- or 16-bit ioctl data, a target back-pressure input, programmable write spacing, and a word-count limit. It sits inside the `hps_io` substitute, between `CtrlModule` and the core's ROM/tape RAM.

## Interface
Parameters:
- `WIDE`, 0: 0 = 8-bit `ioctl_dout` with address step 1; 1 = 16-bit `ioctl_dout` with address step 2.
- `ADDR_W`, 27: width of `ioctl_addr`.
- `SIZE_W`, 16: width of `host_bootdata_size`, counted in 32-bit words.
- `GAP`, 3: minimum idle cycles after each `ioctl_wr` pulse; legal range ≥1.

Ports:
- Clocking and reset: `clk_sys` and `reset`. Reset is synchronous and active-high. The clock is `clk_sys`.
- `clk_sys`  in  1  system clock (52 MHz).
- `reset`  in  1  synchronous active-high reset.
- `host_bootdata`  in  32  word from ZPU.
- `host_bootdata_req`  in  1  level; word valid while high.
- `host_bootdata_ack`  out  1  one-cycle acknowledge.
- `host_bootdata_download`  in  1  transfer window from ZPU.
- `host_bootdata_size`  in  SIZE_W  words to write; 0 = unlimited.
- `host_file_type`  in  3  file type; 3'b111 = ROM.
- `ioctl_download`  out  1  active download.
- `ioctl_index`  out  16  menu index.
- `ioctl_wr`  out  1  one-cycle write strobe.
- `ioctl_addr`  out  ADDR_W  write address.
- `ioctl_dout`  out  (WIDE?16:8)  write data.
- `ioctl_wait`  in  1  target stall; no `ioctl_wr` is issued while high.
- `words_done`  out  SIZE_W  number of words written in the current or last download.

## Operation
States:
- **IDLE**: `ioctl_download`=0.
  - On `host_bootdata_download`=1: clear `ioctl_addr` and `words_done`.
  - Latch `ioctl_index` = (`host_file_type`==3'b111) ? 0 : {13'b0,`host_file_type`}.
  - Set `ioctl_download`=1, go to FETCH.
- **FETCH**:
  - If `host_bootdata_req`: latch the word, pulse `host_bootdata_ack`, go to ACK.
  - Else if `host_bootdata_download`=0: go to DONE.
- **ACK**: wait for `host_bootdata_req`=0. Then:
  - If `host_bootdata_size`≠0 and `words_done`≥`host_bootdata_size`: discard the word, go to FETCH. The word is acked but not written.
  - Otherwise: lane=0, go to EMIT.
- **EMIT**: if `ioctl_wait`=0, drive `ioctl_wr`=1 with the lane data, go to GAP.
- **GAP**: count GAP cycles. Then:
  - If more lanes remain: next lane, go to EMIT.
  - Otherwise: increment `words_done`, go to FETCH.
- **DONE**: `ioctl_download`←0, go to IDLE.

Lane order (big-endian stream, byte at lower address first):
- WIDE=0: bytes [31:24], [23:16], [15:8], [7:0].
- WIDE=1: {[23:16],[31:24]}, then {[7:0],[15:8]}. The even-address byte is in `dout[7:0]`.

Address and counter rules:
- `ioctl_addr` increments by 1 or 2 in the cycle after each `ioctl_wr`.
- `ioctl_addr` wraps modulo 2^ADDR_W.
- `words_done` saturates at all-ones.

Boundary behaviour:
- If `host_bootdata_download` falls mid-word, the latched word is still fully emitted. DONE follows from FETCH.
- If `req` and a falling `host_bootdata_download` coincide in FETCH, `req` wins.

## Timing
- All outputs are registered.
- Reset values: `ioctl_download`, `ioctl_wr`, `host_bootdata_ack`, `ioctl_addr`, `ioctl_dout`, `ioctl_index` and `words_done` are all 0. State resets to IDLE.
- Reset mid-transfer aborts immediately and issues no further writes. A later `host_bootdata_download` restarts from address 0.
- `ioctl_download` rises 1 cycle after `host_bootdata_download` is sampled high in IDLE.
- `ioctl_download` falls 2 cycles after `host_bootdata_download` is sampled low in FETCH.
- Acknowledge: `req` sampled high at cycle t gives `host_bootdata_ack`=1 at t+1, for exactly one cycle.
- First write: `req` sampled low at cycle u in ACK gives EMIT at u+1 and `ioctl_wr` at u+2 at the earliest.
- Write strobe: `ioctl_wr` is high for 1 cycle. `ioctl_addr` and `ioctl_dout` are valid in that cycle and held until the next write.
- Consecutive `ioctl_wr` pulses are at least GAP+1 cycles apart.
- `ioctl_wait` is sampled in EMIT only. A stall of N cycles delays the write by N cycles, with no data loss.

## Structure
- Package `zpu_ioctl_pkg` holds:
  - the state enumeration (IDLE, FETCH, ACK, EMIT, GAP, DONE);
  - `FT_ROM`=3'b111;
  - the file-type→index mapping function.
- `DW` is derived locally from WIDE.
- No sub-module is needed. The lane mux, GAP counter and FSM are all inline in `zpu_ioctl_bridge`.

## Test plan
- **Basic 8-bit transfer**: WIDE=0, size=2, words 0x11223344 then 0x55667788 → 8 writes, addr 0..7, dout 11,22,33,44,55,66,77,88. `words_done`=2. `ioctl_download` drops after the last write.
- **Back-pressure**: WIDE=0, `ioctl_wait` held high for 10 cycles while 0xA1B2C3D4 is in EMIT → no `ioctl_wr` during the stall. All 4 bytes A1,B2,C3,D4 arrive in order at consecutive addresses.
- **16-bit mode**: WIDE=1, word 0xAABBCCDD → writes (addr 0, 0xBBAA) then (addr 2, 0xDDCC). Pulses are ≥4 cycles apart with GAP=3.
- **Size limit**: size=1, ZPU sends 0x01020304 and 0x05060708 → both words acked, only 4 writes (01..04), `words_done`=1.
- **Index mapping**: `host_file_type`=3'b111 → `ioctl_index`=0. `host_file_type`=3'b010 → `ioctl_index`=2.
- **Reset mid-transfer**: `reset` asserted during EMIT of the second word → next cycle all outputs are 0 and the state is IDLE. A new download writes 0x11 first at addr 0.
